player_state_tx: RTL and testbench

PLAYER_STATE_TX -- requirements
Module: player_state_tx

---
 rtl/player_state_tx.sv | 206 ++++++++++++++++++++
 tb/tb_player_state_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_state_tx.sv
// player_state_tx
// Serialises a 6-byte player-state packet over a UART line once per requested
// video frame. Packet layout: HEADER, {game_start,000,health}, x[11:4],
// {x[3:0],y[11:8]}, y[7:0], XOR checksum of the four payload bytes.
// Each byte is sent as 8N1 with no idle gap between bytes of a packet.
//
// Ports
//   clk            system clock (only clock)
//   rst            synchronous active-high reset
//   frame_tick     one-cycle packet request per video frame
//   link_en        transmit enable; requests are ignored while low
//   current_health local player HP (snapshotted at packet start)
//   char_x         local player x position (snapshotted)
//   char_y         local player y position (snapshotted)
//   game_start     local start request flag (snapshotted)
//   tx             registered UART serial output, idles high
//   busy           high while a packet is in flight
//   pkt_sent       high for the final cycle of the last stop bit of a packet
module player_state_tx #(
    parameter int unsigned CLKS_PER_BIT = 565,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        link_en,
    input  logic [3:0]  current_health,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic        game_start,
    output logic        tx,
    output logic        busy,
    output logic        pkt_sent
);

    // Bit-period counter; CLKS_PER_BIT >= 2 keeps the width at least 1.
    localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [2:0]      LastByte = 3'd5;
    localparam logic [2:0]      LastBit  = 3'd7;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic            pending_q, pending_d;
    logic            tx_q, tx_d;

    // Packet snapshot; held constant for the whole packet.
    logic [3:0]      snap_hp_q;
    logic [11:0]     snap_x_q;
    logic [11:0]     snap_y_q;
    logic            snap_gs_q;
    logic            load_snap;

    logic            trig;
    logic            baud_done;
    logic            last_cycle;
    logic [2:0]      bit_nxt;
    logic [7:0]      b1, b2, b3, b4;
    logic [7:0]      cur_byte;

    assign trig       = frame_tick & link_en;
    assign baud_done  = (baud_q == CntMax);
    assign bit_nxt    = bit_q + 3'd1;
    // Final cycle of the B5 stop bit: the packet completes at the next edge.
    assign last_cycle = (state_q == StStop) && (byte_q == LastByte) && baud_done;

    assign b1 = {snap_gs_q, 3'b000, snap_hp_q};
    assign b2 = snap_x_q[11:4];
    assign b3 = {snap_x_q[3:0], snap_y_q[11:8]};
    assign b4 = snap_y_q[7:0];

    always_comb begin
        cur_byte = HEADER;
        case (byte_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
            3'd4:    cur_byte = b4;
            3'd5:    cur_byte = b1 ^ b2 ^ b3 ^ b4;
            default: cur_byte = HEADER;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CntOne;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        load_snap = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (trig) begin
                    state_d   = StStart;
                    bit_d     = '0;
                    byte_d    = '0;
                    tx_d      = 1'b0;
                    load_snap = 1'b1;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != LastByte) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else if (link_en && (pending_q || frame_tick)) begin
                        // A request arriving in the completion cycle counts as
                        // pending, so the next packet follows without a gap.
                        byte_d    = '0;
                        state_d   = StStart;
                        tx_d      = 1'b0;
                        load_snap = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Single-deep request queue; dropping link_en discards it.
    always_comb begin
        pending_d = pending_q;
        if (last_cycle) begin
            pending_d = 1'b0;
        end else if ((state_q != StIdle) && trig) begin
            pending_d = 1'b1;
        end
        if (!link_en) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            pending_q <= 1'b0;
            tx_q      <= 1'b1;
            snap_hp_q <= '0;
            snap_x_q  <= '0;
            snap_y_q  <= '0;
            snap_gs_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            if (load_snap) begin
                snap_hp_q <= current_health;
                snap_x_q  <= char_x;
                snap_y_q  <= char_y;
                snap_gs_q <= game_start;
            end
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign pkt_sent = last_cycle;

endmodule

// File: tb/tb_player_state_tx.sv
// Bench for player_state_tx with CLKS_PER_BIT=4: a packet-level reference model
// predicts tx/busy/pkt_sent every cycle, and a UART receiver recovers bytes
// from tx for directed checks against hand-computed packets.
module tb_player_state_tx;

    localparam int unsigned C         = 4;
    localparam int unsigned PktCycles = 60 * C;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        link_en;
    logic [3:0]  hp;
    logic [11:0] cx;
    logic [11:0] cy;
    logic        gs;
    logic        tx;
    logic        busy;
    logic        pkt_sent;

    always #5 clk = ~clk;

    player_state_tx #(
        .CLKS_PER_BIT(C),
        .HEADER      (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .link_en       (link_en),
        .current_health(hp),
        .char_x        (cx),
        .char_y        (cy),
        .game_start    (gs),
        .tx            (tx),
        .busy          (busy),
        .pkt_sent      (pkt_sent)
    );

    int checks = 0;
    int errs   = 0;

    // Reference model: a packet is a 60-bit frame, each bit held C cycles.
    bit          m_act  = 1'b0;
    bit          m_pend = 1'b0;
    int          m_pos  = 0;
    logic [59:0] m_bits = '1;

    // UART receiver state
    bit          rx_act = 1'b0;
    int          rx_cnt = 0;
    logic [7:0]  rx_byte;
    logic [7:0]  rxq[$];

    int busy_cnt = 0;
    int sent_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [59:0] frame_bits(input logic g, input logic [3:0] h,
                                               input logic [11:0] x, input logic [11:0] y);
        logic [7:0]  b[6];
        logic [59:0] f;
        b[0] = 8'hA5;
        b[1] = {g, 3'b000, h};
        b[2] = x[11:4];
        b[3] = {x[3:0], y[11:8]};
        b[4] = y[7:0];
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < 6; i++) begin
            f[i*10] = 1'b0;
            for (int j = 0; j < 8; j++) f[i*10+1+j] = b[i][j];
            f[i*10+9] = 1'b1;
        end
        return f;
    endfunction

    task automatic model_load();
        m_act  = 1'b1;
        m_pos  = 0;
        m_pend = 1'b0;
        m_bits = frame_bits(gs, hp, cx, cy);
    endtask

    // One clock: advance the model with the inputs now applied, clock the DUT,
    // then compare at the falling edge and feed the receiver.
    task automatic step();
        logic exp_tx;
        logic exp_sent;
        bit   req;
        bit   was_rst;
        req     = frame_tick && link_en;
        was_rst = rst;
        if (rst) begin
            m_act  = 1'b0;
            m_pend = 1'b0;
        end else if (!m_act) begin
            if (req) model_load();
        end else if (m_pos == PktCycles - 1) begin
            if (link_en && (m_pend || frame_tick)) model_load();
            else m_act = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_pos++;
            if (req) m_pend = 1'b1;
            if (!link_en) m_pend = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);

        exp_tx   = m_act ? m_bits[m_pos / C] : 1'b1;
        exp_sent = m_act && (m_pos == PktCycles - 1);
        check_eq("tx", tx, exp_tx);
        check_eq("busy", busy, m_act);
        check_eq("pkt_sent", pkt_sent, exp_sent);
        if (busy) busy_cnt++;
        if (pkt_sent) sent_cnt++;

        if (was_rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_act && (rx_cnt % C == C / 2)) begin
            int k;
            k = rx_cnt / C;
            if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
            if (k == 9) begin
                rxq.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic clr();
        rxq.delete();
        busy_cnt = 0;
        sent_cnt = 0;
    endtask

    task automatic check_pkt(input string tag, input int base, input logic [47:0] exp);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] got;
            got = (rxq.size() > base + i) ? rxq[base+i] : 8'hxx;
            check_eq(tag, got, exp[47-8*i -: 8]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        link_en    = 1'b1;
        hp         = '0;
        cx         = '0;
        cy         = '0;
        gs         = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;  // reset must win over a coincident tick
        run(2);
        frame_tick = 1'b0;
        check_eq("reset_tx", tx, 1'b1);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_pkt_sent", pkt_sent, 1'b0);
        rst = 1'b0;
        run(3);

        // Basic packet
        hp = 4'd7; cx = 12'h123; cy = 12'h456; gs = 1'b0;
        clr();
        pulse_tick();
        check_eq("basic_tx_low", tx, 1'b0);
        check_eq("basic_busy_high", busy, 1'b1);
        run(259);
        check_eq("basic_nbytes", rxq.size(), 6);
        check_pkt("basic_byte", 0, 48'hA5_07_12_34_56_77);
        check_eq("basic_busy_cycles", busy_cnt, 240);
        check_eq("basic_sent_pulses", sent_cnt, 1);

        // Snapshot held while inputs change mid-packet
        clr();
        pulse_tick();
        run(49);
        cx = 12'h0FF;
        run(210);
        check_pkt("snap_byte", 0, 48'hA5_07_12_34_56_77);
        cx = 12'h123;

        // Pending: one queued request, extra tick dropped, second packet
        // carries the inputs present in the first packet's completion cycle
        clr();
        run(30);
        pulse_tick();
        run(69);
        pulse_tick();
        run(19);
        pulse_tick();
        run(79);
        cx = 12'hABC;
        run(360);
        check_eq("pend_nbytes", rxq.size(), 12);
        check_pkt("pend_first", 0, 48'hA5_07_12_34_56_77);
        check_pkt("pend_second", 6, 48'hA5_07_AB_C4_56_3E);
        check_eq("pend_busy_cycles", busy_cnt, 480);
        check_eq("pend_sent_pulses", sent_cnt, 2);

        // Tick in the completion cycle of an unqueued packet
        cx = 12'h123;
        clr();
        pulse_tick();
        run(239);
        pulse_tick();
        run(260);
        check_eq("coinc_sent_pulses", sent_cnt, 2);
        check_eq("coinc_busy_cycles", busy_cnt, 480);
        check_eq("coinc_nbytes", rxq.size(), 12);

        // Disabled link
        link_en = 1'b0;
        clr();
        pulse_tick();
        run(20);
        check_eq("dis_busy_cycles", busy_cnt, 0);
        check_eq("dis_nbytes", rxq.size(), 0);
        link_en = 1'b1;

        // Reset mid-packet, then a fresh packet
        clr();
        pulse_tick();
        run(76);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_mid_tx", tx, 1'b1);
        check_eq("rst_mid_busy", busy, 1'b0);
        clr();
        run(4);
        pulse_tick();
        run(260);
        check_eq("rst_nbytes", rxq.size(), 6);
        check_pkt("rst_byte", 0, 48'hA5_07_12_34_56_77);
        check_eq("rst_sent_pulses", sent_cnt, 1);

        // Checksum with game_start and full HP
        gs = 1'b1; hp = 4'hF; cx = '0; cy = '0;
        clr();
        pulse_tick();
        run(260);
        check_pkt("csum_byte", 0, 48'hA5_8F_00_00_00_8F);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) link_en = ~link_en;
            rst = ($urandom_range(0, 1499) == 0);
            hp  = 4'($urandom);
            cx  = 12'($urandom);
            cy  = 12'($urandom);
            gs  = 1'($urandom);
            step();
        end
        frame_tick = 1'b0;
        rst        = 1'b0;
        link_en    = 1'b1;
        run(2 * PktCycles + 10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
